cobra_run_ctrl: RTL and testbench

Run/halt/single-step sequencer for the CYBERcobra core. It drives a single clock-enable that gates the PC update and register-file write, so the core can be halted, stepped one instruction at a time, or stopped at a PC breakpoint. It also keeps a retired-instruction counter. It sits between the board buttons/switches and the core's enable inputs.

---
 rtl/cobra_ctrl_pkg.sv | 23 ++
 rtl/cobra_bp_cmp.sv | 40 ++++
 rtl/cobra_run_ctrl.sv | 131 +++++++++++++
 tb/tb_cobra_run_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cobra_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cobra_ctrl_pkg
// Description : Shared types and constants for the CYBERcobra run/halt/step
//               sequencer (state encodings, retired-counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package cobra_ctrl_pkg;

    // Width of the retired-instruction counter.
    localparam int unsigned c_CNT_W = 32;

    // Sequencer states. ST_ILLEGAL is listed so the encoding space is
    // complete; the FSM recovers from it to ST_HALT.
    typedef enum logic [1:0] {
        ST_HALT    = 2'b00,
        ST_RUN     = 2'b01,
        ST_STEP    = 2'b10,
        ST_ILLEGAL = 2'b11
    } run_state_e;

endpackage
`default_nettype wire

// File: rtl/cobra_bp_cmp.sv
`default_nettype none
// ============================================================================
// Module      : cobra_bp_cmp
// Description : PC breakpoint register and comparator. A loaded value is
//               used from the cycle after the write. The match is suppressed
//               while first_run is set so a resume from the breakpoint PC
//               executes that instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module cobra_bp_cmp
    import cobra_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_bp_we,
    input  logic [31:0] i_bp_addr,
    input  logic        i_bp_valid,
    input  logic [31:0] i_pc,
    input  logic        i_first_run,
    output logic        o_match
);

    logic        r_bp_valid;
    logic [31:0] r_bp_addr;

    // Breakpoint register: loaded on a write strobe in any sequencer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bp_valid <= 1'b0;
            r_bp_addr  <= 32'h0000_0000;
        end else if (i_bp_we) begin
            r_bp_valid <= i_bp_valid;
            r_bp_addr  <= i_bp_addr;
        end
    end

    assign o_match = r_bp_valid && (i_pc == r_bp_addr) && !i_first_run;

endmodule
`default_nettype wire

// File: rtl/cobra_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cobra_run_ctrl
// Description : Run/halt/single-step sequencer for the CYBERcobra core.
//               Produces the core clock-enable and counts retired cycles.
//               Optional PC breakpoint built when COBRA_RUN_CTRL_BP_EN is
//               defined; otherwise the breakpoint ports are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module cobra_run_ctrl
    import cobra_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               run_i,
    input  logic               halt_i,
    input  logic               step_i,
    input  logic [31:0]        pc_i,
    input  logic               bp_we_i,
    input  logic [31:0]        bp_addr_i,
    input  logic               bp_valid_i,
    input  logic               clr_cnt_i,
    output logic               core_en_o,
    output logic [1:0]         state_o,
    output logic               halted_o,
    output logic               bp_hit_o,
    output logic [c_CNT_W-1:0] retired_o
);

    run_state_e         r_state;
    run_state_e         w_state_nxt;
    logic               w_match;
    logic               w_core_en;
    logic [c_CNT_W-1:0] r_retired;

`ifdef COBRA_RUN_CTRL_BP_EN
    logic r_first_run;
    logic r_bp_hit;

    cobra_bp_cmp u_bp_cmp (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_bp_we     (bp_we_i),
        .i_bp_addr   (bp_addr_i),
        .i_bp_valid  (bp_valid_i),
        .i_pc        (pc_i),
        .i_first_run (r_first_run),
        .o_match     (w_match)
    );

    // first_run marks the first RUN cycle after a resume; bp_hit pulses
    // the cycle after a breakpoint stop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_first_run <= 1'b0;
            r_bp_hit    <= 1'b0;
        end else begin
            r_first_run <= (r_state == ST_HALT) && (w_state_nxt == ST_RUN);
            r_bp_hit    <= (r_state == ST_RUN) && w_match;
        end
    end

    assign bp_hit_o = r_bp_hit;
`else
    logic w_unused_bp;

    assign w_unused_bp = ^{bp_we_i, bp_addr_i, bp_valid_i, pc_i};
    assign w_match     = 1'b0;
    assign bp_hit_o    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and core enable; halt beats step beats run.
    always_comb begin
        w_state_nxt = r_state;
        w_core_en   = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (!halt_i) begin
                    if (step_i) begin
                        w_state_nxt = ST_STEP;
                    end else if (run_i) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // A halt lets the current instruction retire; a breakpoint
                // stops before it.
                w_core_en = !w_match;
                if (halt_i || w_match) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_STEP: begin
                w_core_en   = 1'b1;
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase
        if (rst_i) begin
            w_core_en = 1'b0;
        end
    end

    // Retired counter: clear wins over increment, wraps naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
            r_retired <= '0;
        end else if (w_core_en) begin
            r_retired <= r_retired + c_CNT_W'(1);
        end
    end

    assign core_en_o = w_core_en;
    assign state_o   = r_state;
    assign halted_o  = (r_state == ST_HALT);
    assign retired_o = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_cobra_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cobra_run_ctrl
// Description : Scoreboard bench for cobra_run_ctrl. The stimulus side keeps
//               a behavioural model of the sequencer and queues the expected
//               outputs for each cycle; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cobra_run_ctrl;

`ifdef COBRA_RUN_CTRL_BP_EN
    localparam bit c_BP_ON = 1'b1;
`else
    localparam bit c_BP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        run_i = 1'b0;
    logic        halt_i = 1'b0;
    logic        step_i = 1'b0;
    logic [31:0] pc_i = 32'h0;
    logic        bp_we_i = 1'b0;
    logic [31:0] bp_addr_i = 32'h0;
    logic        bp_valid_i = 1'b0;
    logic        clr_cnt_i = 1'b0;
    logic        core_en_o;
    logic [1:0]  state_o;
    logic        halted_o;
    logic        bp_hit_o;
    logic [31:0] retired_o;

    always #5 clk = ~clk;

    cobra_run_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .run_i      (run_i),
        .halt_i     (halt_i),
        .step_i     (step_i),
        .pc_i       (pc_i),
        .bp_we_i    (bp_we_i),
        .bp_addr_i  (bp_addr_i),
        .bp_valid_i (bp_valid_i),
        .clr_cnt_i  (clr_cnt_i),
        .core_en_o  (core_en_o),
        .state_o    (state_o),
        .halted_o   (halted_o),
        .bp_hit_o   (bp_hit_o),
        .retired_o  (retired_o)
    );

    typedef struct {
        bit          known;
        bit          en;
        logic [1:0]  st;
        bit          halted;
        bit          hit;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: the sequencer described as "running", "one shot
    // pending" and "just resumed" facts plus a core PC that advances by 4
    // on every enabled cycle.
    bit          m_known   = 1'b0;
    bit          m_running = 1'b0;
    bit          m_oneshot = 1'b0;
    bit          m_resumed = 1'b0;
    bit          m_hit     = 1'b0;
    bit          m_bp_v    = 1'b0;
    logic [31:0] m_bp_a    = 32'h0;
    logic [31:0] m_cnt     = 32'h0;
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] pc_mask   = 32'hFFFF_FFFF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; queues the outputs the model predicts for
    // this cycle, then moves the model past the coming edge.
    task automatic drive(input bit rst, input bit run, input bit halt, input bit step,
                         input bit clr, input bit bp_we, input logic [31:0] bp_a,
                         input bit bp_v);
        exp_t e;
        bit   match;
        bit   en;
        @(posedge clk);
        #1;
        rst_i      = rst;
        run_i      = run;
        halt_i     = halt;
        step_i     = step;
        clr_cnt_i  = clr;
        bp_we_i    = bp_we;
        bp_addr_i  = bp_a;
        bp_valid_i = bp_v;
        pc_i       = m_pc;

        match    = c_BP_ON && m_bp_v && (m_pc == m_bp_a) && !m_resumed;
        en       = !rst && ((m_running && !match) || m_oneshot);
        e.known  = m_known;
        e.en     = en;
        e.st     = m_running ? 2'b01 : (m_oneshot ? 2'b10 : 2'b00);
        e.halted = !m_running && !m_oneshot;
        e.hit    = m_hit;
        e.cnt    = m_cnt;
        q.push_back(e);

        if (rst) begin
            m_known   = 1'b1;
            m_running = 1'b0;
            m_oneshot = 1'b0;
            m_resumed = 1'b0;
            m_hit     = 1'b0;
            m_bp_v    = 1'b0;
            m_bp_a    = 32'h0;
            m_cnt     = 32'h0;
        end else begin
            m_hit     = m_running && match;
            m_cnt     = clr ? 32'h0 : (m_cnt + {31'b0, en});
            if (bp_we) begin
                m_bp_v = bp_v;
                m_bp_a = bp_a;
            end
            m_resumed = 1'b0;
            if (m_oneshot) begin
                m_oneshot = 1'b0;
            end else if (m_running) begin
                if (halt || match) m_running = 1'b0;
            end else if (!halt) begin
                if (step) begin
                    m_oneshot = 1'b1;
                end else if (run) begin
                    m_running = 1'b1;
                    m_resumed = 1'b1;
                end
            end
        end
        if (en) m_pc = (m_pc + 32'd4) & pc_mask;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    // Monitor: compares every cycle's outputs with the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("core_en", {31'b0, core_en_o}, {31'b0, e.en});
                if (e.known) begin
                    chk("state", {30'b0, state_o}, {30'b0, e.st});
                    chk("halted", {31'b0, halted_o}, {31'b0, e.halted});
                    chk("bp_hit", {31'b0, bp_hit_o}, {31'b0, e.hit});
                    chk("retired", retired_o, e.cnt);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a4;

        // Reset then idle.
        drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
        idle(10);
        @(negedge clk);
        chk("reset_halted", {31'b0, halted_o}, 32'd1);
        chk("reset_core_en", {31'b0, core_en_o}, 32'd0);
        chk("reset_retired", retired_o, 32'd0);

        // Three single steps, four cycles apart.
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 0, 0, 32'h0, 0);
            idle(3);
        end
        idle(1);
        @(negedge clk);
        chk("step_retired", retired_o, 32'd3);
        chk("step_halted", {31'b0, halted_o}, 32'd1);

        // Run 20 cycles then halt; the halt cycle retires too.
        drive(0, 0, 0, 0, 1, 0, 32'h0, 0);
        drive(0, 1, 0, 0, 0, 0, 32'h0, 0);
        idle(20);
        drive(0, 0, 1, 0, 0, 0, 32'h0, 0);
        idle(1);
        @(negedge clk);
        chk("run_retired", retired_o, 32'd21);
        chk("run_state", {30'b0, state_o}, 32'd0);

        // Breakpoint at 0x10, PC from 0.
        m_pc = 32'h0;
        drive(0, 0, 0, 0, 1, 1, 32'h0000_0010, 1);
        drive(0, 1, 0, 0, 0, 0, 32'h0, 0);
        idle(4);
        idle(1);
        @(negedge clk);
        chk("bp_core_en", {31'b0, core_en_o}, c_BP_ON ? 32'd0 : 32'd1);
        idle(1);
        @(negedge clk);
        chk("bp_hit_pulse", {31'b0, bp_hit_o}, c_BP_ON ? 32'd1 : 32'd0);
        chk("bp_retired", retired_o, c_BP_ON ? 32'd4 : 32'd5);
        drive(0, 0, 1, 0, 0, 0, 32'h0, 0);
        drive(0, 1, 0, 0, 0, 0, 32'h0, 0);
        idle(1);
        idle(1);
        @(negedge clk);
        chk("bp_resume_retired", retired_o, c_BP_ON ? 32'd5 : 32'd8);
        drive(0, 0, 1, 0, 0, 0, 32'h0, 0);

        // All three commands together in HALT: halt wins, stay halted.
        drive(0, 1, 1, 1, 0, 0, 32'h0, 0);
        idle(1);
        @(negedge clk);
        chk("combo_state", {30'b0, state_o}, 32'd0);
        chk("combo_core_en", {31'b0, core_en_o}, 32'd0);

        // Counter clear while running.
        drive(0, 1, 0, 0, 0, 0, 32'h0, 0);
        idle(3);
        drive(0, 0, 0, 0, 1, 0, 32'h0, 0);
        idle(1);
        @(negedge clk);
        chk("clr_retired0", retired_o, 32'd0);
        idle(1);
        @(negedge clk);
        chk("clr_retired1", retired_o, 32'd1);
        drive(0, 0, 1, 0, 0, 0, 32'h0, 0);

        // Randomised traffic in a small PC window so breakpoints recur.
        pc_mask = 32'h0000_003C;
        m_pc    = m_pc & pc_mask;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) m_pc = 32'($urandom) & pc_mask;
            a4 = 4'($urandom_range(0, 15));
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 9) == 0,
                  {26'b0, a4, 2'b00},
                  $urandom_range(0, 3) != 0);
        end

        idle(2);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
